fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
Round-robin write arbiter that shares the write port of one `fifo` instance among NUM_REQ requesters, such as UART RX, the CPU MMIO store path and a debug injector.
- Each requester presents a valid/ready stream.
- The arbiter grants one requester at a time for a burst of up to MAX_BURST beats, then rotates.
- It sits directly in front of the `fifo` write side (wr_en/din/full) in io_circuits.

Parameters:
NUM_REQ, 4, number of requesters (≥2)
DATA_WIDTH, 8, beat width; must match the FIFO data_width
MAX_BURST, 4, maximum beats per grant (≥1)
ID_WIDTH, $clog2(NUM_REQ), width of the requester index

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous reset, active-low
req_valid  in  NUM_REQ  per-requester data valid
req_data  in  NUM_REQ*DATA_WIDTH  packed data; requester i at [i*DATA_WIDTH +: DATA_WIDTH]
req_ready  out  NUM_REQ  per-requester accept; a beat transfers when valid&ready
fifo_wr_en  out  1  to FIFO wr_en
fifo_din  out  DATA_WIDTH  to FIFO din
fifo_full  in  1  from FIFO full
grant_valid  out  1  a requester currently holds the grant
grant_id  out  ID_WIDTH  index of the granted requester

Behaviour:
- Reset (rst_n=0 at posedge):
  - state=IDLE, grant_valid=0, grant_id=0, beat_cnt=0.
  - last_id=NUM_REQ-1, so requester 0 has first priority.
  - Combinational outputs therefore reset to req_ready=0, fifo_wr_en=0, fifo_din=0.
  - Reset mid-burst aborts the grant immediately. No write occurs in the reset cycle.
- States: IDLE, GRANT. grant_valid=(state==GRANT).
- Pick function: the first index with req_valid=1, searching (last_id+1) mod NUM_REQ upward with wrap.
- IDLE:
  - If any req_valid: state<=GRANT, grant_id<=pick, beat_cnt<=0.
  - Otherwise stay in IDLE.
  - Arbitration latency is 1 cycle: valid seen at cycle N gives the first write at N+1 at the earliest.
- GRANT (g=grant_id), combinational outputs:
  - beat = req_valid[g] & ~fifo_full.
  - fifo_wr_en=beat.
  - fifo_din=req_data[g].
  - req_ready[g]=~fifo_full; all other req_ready=0.
- Release condition: (beat & beat_cnt==MAX_BURST-1) OR ~req_valid[g].
  - On release: last_id<=g, beat_cnt<=0.
  - If any req_valid (evaluated with the updated rotation, i.e. search from g+1): stay in GRANT with the new grant_id=pick. No idle bubble.
  - Otherwise: state<=IDLE.
  - The same requester may be re-granted if it is the only one valid.
- No release: beat_cnt<=beat_cnt+beat.
- fifo_full: stalls without consuming burst budget. Grant is held indefinitely while full and req_valid[g]=1; there is no timeout.
- Requester dropping valid mid-burst: the grant is released in that same cycle's transition and no beat is written.
- fifo_din is driven 0 when grant_valid=0. No X propagation.
- Width rules:
  - beat_cnt is $clog2(MAX_BURST+1) bits.
  - All index arithmetic is modulo NUM_REQ; non-power-of-2 NUM_REQ must wrap correctly (e.g. 3→0).
- Data ordering: beats from one requester reach the FIFO in order. Interleaving across requesters happens only at burst boundaries.

Decomposition:
- Package io_arb_pkg:
  - state encoding localparams ARB_IDLE=1'b0, ARB_GRANT=1'b1.
  - Default-parameter constants.
- Sub-module rr_pick (combinational):
  - Inputs: req vector and last_id.
  - Outputs: pick index and any_valid.
  - Implemented as rotate, priority-encode, un-rotate.
  - Reused by future read-side schedulers.

Test Plan:
- Single requester 2 valid for 3 beats, data 0xA1,0xA2,0xA3, FIFO empty -> grant_id=2 one cycle later; 3 consecutive fifo_wr_en pulses with those bytes; IDLE after valid drops.
- All 4 requesters continuously valid, MAX_BURST=4 -> grant order 0,1,2,3,0; exactly 4 beats each; no idle cycle between grants; 16 writes in 16 consecutive cycles after the first grant.
- Requester 1 granted, fifo_full asserted for 5 cycles after beat 2 -> fifo_wr_en=0 and req_ready[1]=0 during full; grant held; beat_cnt stays 2; remaining 2 beats written after full drops; then rotates.
- Requester 0 drops valid after 1 beat while requester 3 valid -> release; next grant_id=3 next cycle; later with only requester 0 valid, it is re-granted.
- Reset mid-burst (rst_n=0 one cycle at beat 2 of requester 2) -> that cycle no fifo_wr_en; after reset grant_valid=0; first new grant goes to the lowest valid index starting at 0.
- NUM_REQ=3 build, requesters 0 and 2 valid -> alternates 0,2,0,2; wrap from index 2 to 0 is correct.

Source files
------------

// File: rtl/io_arb_pkg.sv
// Shared types and default sizing for the io write-side arbiters.
// Imported by fifo_wr_arbiter and rr_pick.
package io_arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

    localparam int ARB_NUM_REQ    = 4;
    localparam int ARB_DATA_WIDTH = 8;
    localparam int ARB_MAX_BURST  = 4;

endpackage

// File: rtl/rr_pick.sv
// Round-robin pick: first set request after last_id, wrapping.
// Rotate, priority-encode, then un-rotate back to an index.
module rr_pick
    import io_arb_pkg::*;
#(
    parameter int NUM_REQ  = ARB_NUM_REQ,
    parameter int ID_WIDTH = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [ID_WIDTH-1:0] last_id,
    output logic [ID_WIDTH-1:0] pick,
    output logic                any_valid
);

    logic [NUM_REQ-1:0] rot;
    logic               hit;
    int                 off;

    assign any_valid = |req;

    // rotate so slot 0 is last_id+1, take lowest hit, map back
    always_comb begin
        rot  = '0;
        hit  = 1'b0;
        off  = 0;
        pick = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            rot[j] = req[(int'(last_id) + 1 + j) % NUM_REQ];
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!hit && rot[j]) begin
                hit = 1'b1;
                off = j;
            end
        end
        pick = ID_WIDTH'((int'(last_id) + 1 + off) % NUM_REQ);
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port.
// Grants one requester for up to MAX_BURST beats, then rotates.
module fifo_wr_arbiter
    import io_arb_pkg::*;
#(
    parameter int NUM_REQ    = ARB_NUM_REQ,
    parameter int DATA_WIDTH = ARB_DATA_WIDTH,
    parameter int MAX_BURST  = ARB_MAX_BURST,
    parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_din,
    input  logic                          fifo_full,
    output logic                          grant_valid,
    output logic [ID_WIDTH-1:0]           grant_id
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    arb_state_t          state;
    logic [ID_WIDTH-1:0] last_id;
    logic [ID_WIDTH-1:0] search_base;
    logic [ID_WIDTH-1:0] pick;
    logic                any_valid;
    logic [CNT_W-1:0]    beat_cnt;
    logic                sel_valid;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                beat;
    logic                release_g;

    assign grant_valid = (state == ARB_GRANT);

    // on release the search must start after the current holder
    assign search_base = grant_valid ? grant_id : last_id;

    rr_pick #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_pick (
        .req       (req_valid),
        .last_id   (search_base),
        .pick      (pick),
        .any_valid (any_valid)
    );

    // mux out the granted lane's valid and data
    always_comb begin
        sel_valid = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == ID_WIDTH'(i)) begin
                sel_valid = req_valid[i];
                sel_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // no write may leave during a reset cycle
    assign beat = grant_valid & sel_valid & ~fifo_full & rst_n;

    assign release_g = (beat && beat_cnt == CNT_W'(MAX_BURST - 1))
                     || !sel_valid;

    assign fifo_wr_en = beat;
    assign fifo_din   = grant_valid ? sel_data : '0;

    // only the holder sees ready, and only while the FIFO has room
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = grant_valid && (grant_id == ID_WIDTH'(i))
                         && !fifo_full && rst_n;
        end
    end

    // grant FSM: idle/grant, burst counting and rotation
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ARB_IDLE;
            grant_id <= '0;
            beat_cnt <= '0;
            last_id  <= ID_WIDTH'(NUM_REQ - 1);
        end else begin
            unique case (state)
                ARB_IDLE: begin
                    if (any_valid) begin
                        state    <= ARB_GRANT;
                        grant_id <= pick;
                        beat_cnt <= '0;
                    end
                end
                ARB_GRANT: begin
                    if (release_g) begin
                        last_id  <= grant_id;
                        beat_cnt <= '0;
                        if (any_valid) begin
                            grant_id <= pick;
                        end else begin
                            state <= ARB_IDLE;
                        end
                    end else begin
                        beat_cnt <= beat_cnt + CNT_W'(beat);
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter (4-req and 3-req builds).
// Reference model tracks holder, beats used and rotation as plain ints.
module tb_fifo_wr_arbiter;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        fifo_wr_en;
    logic [7:0]  fifo_din;
    logic        fifo_full;
    logic        grant_valid;
    logic [1:0]  grant_id;

    logic        rst3_n;
    logic [2:0]  req_valid3;
    logic [23:0] req_data3;
    logic [2:0]  req_ready3;
    logic        wr3;
    logic [7:0]  din3;
    logic        full3;
    logic        gv3;
    logic [1:0]  gid3;

    fifo_wr_arbiter #(
        .NUM_REQ(4), .DATA_WIDTH(8), .MAX_BURST(4)
    ) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready),
        .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din),
        .fifo_full(fifo_full),
        .grant_valid(grant_valid), .grant_id(grant_id)
    );

    fifo_wr_arbiter #(
        .NUM_REQ(3), .DATA_WIDTH(8), .MAX_BURST(2)
    ) u_dut3 (
        .clk(clk), .rst_n(rst3_n),
        .req_valid(req_valid3), .req_data(req_data3),
        .req_ready(req_ready3),
        .fifo_wr_en(wr3), .fifo_din(din3),
        .fifo_full(full3),
        .grant_valid(gv3), .grant_id(gid3)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int ecnt   = 0;

    bit m_act [2];
    int m_gid [2];
    int m_used[2];
    int m_last[2];

    // obs/exp layout: {gv, gid[1:0], wr, din[7:0], ready[3:0]}
    logic [15:0] exp_obs, obs;
    logic [3:0]  exp_rdy;

    int          rem[4];
    logic [7:0]  nxt[4];
    logic [9:0]  wlog[$];
    int          wcyc[$];

    function automatic int n_of(input int w);
        return (w != 0) ? 3 : 4;
    endfunction

    function automatic int mb_of(input int w);
        return (w != 0) ? 2 : 4;
    endfunction

    function automatic int search(input int last, input logic [3:0] v,
                                  input int n);
        for (int k = 1; k <= n; k++) begin
            if (v[(last + k) % n]) return (last + k) % n;
        end
        return -1;
    endfunction

    task automatic model_reset(input int w);
        m_act[w]  = 1'b0;
        m_gid[w]  = 0;
        m_used[w] = 0;
        m_last[w] = n_of(w) - 1;
    endtask

    task automatic step(input int w, input logic [3:0] v,
                        input logic [31:0] d, input logic full,
                        input logic rst);
        bit         beat;
        int         p;
        logic [7:0] din_e;
        if (w == 0) begin
            req_valid = v; req_data = d; fifo_full = full; rst_n = ~rst;
            rst3_n = 1'b0; req_valid3 = '0; req_data3 = '0; full3 = 1'b0;
        end else begin
            req_valid3 = v[2:0]; req_data3 = d[23:0];
            full3 = full; rst3_n = ~rst;
            rst_n = 1'b0; req_valid = '0; req_data = '0; fifo_full = 1'b0;
        end
        beat  = m_act[w] && v[m_gid[w]] && !full && !rst;
        din_e = m_act[w] ? d[m_gid[w]*8 +: 8] : 8'h00;
        exp_rdy = '0;
        if (m_act[w] && !full && !rst) exp_rdy[m_gid[w]] = 1'b1;
        exp_obs = {m_act[w], 2'(m_gid[w]), beat, din_e, exp_rdy};
        @(negedge clk);
        if (w == 0)
            obs = {grant_valid, grant_id, fifo_wr_en, fifo_din, req_ready};
        else
            obs = {gv3, gid3, wr3, din3, 1'b0, req_ready3};
        if (obs[12] === 1'b1) begin
            wlog.push_back({obs[14:13], obs[11:4]});
            wcyc.push_back(cyc);
        end
        if (beat) ecnt++;
        @(posedge clk);
        if (rst) begin
            model_reset(w);
        end else if (!m_act[w]) begin
            p = search(m_last[w], v, n_of(w));
            if (p >= 0) begin
                m_act[w] = 1'b1; m_gid[w] = p; m_used[w] = 0;
            end
        end else if ((beat && m_used[w] == mb_of(w) - 1)
                     || !v[m_gid[w]]) begin
            m_last[w] = m_gid[w];
            m_used[w] = 0;
            p = search(m_last[w], v, n_of(w));
            if (p >= 0) m_gid[w] = p;
            else        m_act[w] = 1'b0;
        end else begin
            m_used[w] += int'(beat);
        end
        model_reset(1 - w);
        cyc++;
        #1;
    endtask

    task automatic src_cycle(input int w, input logic full,
                             input logic rst);
        logic [3:0]  v;
        logic [31:0] d;
        v = '0;
        d = '0;
        for (int i = 0; i < 4; i++) begin
            if (rem[i] > 0 && (w == 0 || i < 3)) v[i] = 1'b1;
            d[i*8 +: 8] = nxt[i];
        end
        step(w, v, d, full, rst);
        for (int i = 0; i < 4; i++) begin
            if (v[i] && exp_rdy[i]) begin
                rem[i]--;
                nxt[i]++;
            end
        end
    endtask

    task automatic do_reset(input int w);
        for (int i = 0; i < 4; i++) rem[i] = 0;
        src_cycle(w, 1'b0, 1'b1);
        checks++;
        if (obs !== exp_obs) begin
            errors++;
            $display("FAIL reset_cycle obs=%h exp=%h", obs, exp_obs);
        end
        ecnt = 0;
        wlog.delete();
        wcyc.delete();
    endtask

    task automatic test_reset();
        model_reset(0);
        model_reset(1);
        step(0, 4'hF, $urandom(), 1'b0, 1'b1);
        step(0, 4'h0, $urandom(), 1'b0, 1'b0);
        checks++;
        if (obs !== 16'h0000) begin
            errors++;
            $display("FAIL reset_state obs=%h exp=0000", obs);
        end
        step(1, 4'h0, $urandom(), 1'b0, 1'b0);
        checks++;
        if (obs !== 16'h0000) begin
            errors++;
            $display("FAIL reset_state3 obs=%h exp=0000", obs);
        end
    endtask

    task automatic test_single();
        logic [9:0] e[3];
        e = '{10'h2A1, 10'h2A2, 10'h2A3};
        do_reset(0);
        rem[2] = 3;
        nxt[2] = 8'hA1;
        for (int c = 0; c < 6; c++) begin
            src_cycle(0, 1'b0, 1'b0);
            checks++;
            if (obs !== exp_obs) begin
                errors++;
                $display("FAIL single c%0d obs=%h exp=%h", c, obs, exp_obs);
            end
        end
        checks++;
        if (wlog.size() != 3) begin
            errors++;
            $display("FAIL single_count got=%0d exp=3", wlog.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (wlog[k] !== e[k] || wcyc[k] != cyc - 6 + 1 + k) begin
                    errors++;
                    $display("FAIL single_w%0d got=%h@%0d exp=%h@%0d",
                             k, wlog[k], wcyc[k], e[k], cyc - 5 + k);
                end
            end
        end
        checks++;
        if (obs[15] !== 1'b0) begin
            errors++;
            $display("FAIL single_idle gv=%b exp=0", obs[15]);
        end
    endtask

    task automatic test_all_valid();
        int         c0;
        logic [9:0] e;
        do_reset(0);
        for (int i = 0; i < 4; i++) begin
            rem[i] = 100;
            nxt[i] = 8'(i << 4);
        end
        c0 = cyc;
        for (int c = 0; c < 18; c++) begin
            src_cycle(0, 1'b0, 1'b0);
            checks++;
            if (obs !== exp_obs) begin
                errors++;
                $display("FAIL allv c%0d obs=%h exp=%h", c, obs, exp_obs);
            end
        end
        checks++;
        if (wlog.size() != 17) begin
            errors++;
            $display("FAIL allv_count got=%0d exp=17", wlog.size());
        end else begin
            for (int k = 0; k < 17; k++) begin
                if (k < 16) e = {2'(k / 4), 4'(k / 4), 4'(k % 4)};
                else        e = 10'h004;
                checks++;
                if (wlog[k] !== e || wcyc[k] != c0 + 1 + k) begin
                    errors++;
                    $display("FAIL allv_w%0d got=%h@%0d exp=%h@%0d",
                             k, wlog[k], wcyc[k], e, c0 + 1 + k);
                end
            end
        end
    endtask

    task automatic test_full_stall();
        int         stall;
        logic       full;
        logic [9:0] e[5];
        e = '{10'h110, 10'h111, 10'h112, 10'h113, 10'h220};
        do_reset(0);
        rem[1] = 4; nxt[1] = 8'h10;
        rem[2] = 1; nxt[2] = 8'h20;
        stall = 0;
        for (int c = 0; c < 16; c++) begin
            full = (ecnt == 2 && stall < 5);
            if (full) stall++;
            src_cycle(0, full, 1'b0);
            checks++;
            if (obs !== exp_obs) begin
                errors++;
                $display("FAIL full c%0d obs=%h exp=%h", c, obs, exp_obs);
            end
            if (full) begin
                checks++;
                if (obs[15:12] !== 4'b1010 || obs[3:0] !== 4'h0) begin
                    errors++;
                    $display("FAIL full_hold c%0d obs=%h exp=gv1 id1 wr0 rdy0",
                             c, obs);
                end
            end
        end
        checks++;
        if (wlog.size() != 5) begin
            errors++;
            $display("FAIL full_count got=%0d exp=5", wlog.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                checks++;
                if (wlog[k] !== e[k]) begin
                    errors++;
                    $display("FAIL full_w%0d got=%h exp=%h", k, wlog[k], e[k]);
                end
            end
            checks++;
            if (wcyc[2] - wcyc[1] != 6) begin
                errors++;
                $display("FAIL full_gap got=%0d exp=6", wcyc[2] - wcyc[1]);
            end
        end
    endtask

    task automatic test_drop();
        logic [9:0] e[9];
        e = '{10'h040, 10'h370, 10'h371, 10'h041, 10'h042,
              10'h043, 10'h044, 10'h045, 10'h046};
        do_reset(0);
        rem[0] = 1; nxt[0] = 8'h40;
        rem[3] = 2; nxt[3] = 8'h70;
        for (int c = 0; c < 18; c++) begin
            if (c == 8) rem[0] = 6;
            src_cycle(0, 1'b0, 1'b0);
            checks++;
            if (obs !== exp_obs) begin
                errors++;
                $display("FAIL drop c%0d obs=%h exp=%h", c, obs, exp_obs);
            end
        end
        checks++;
        if (wlog.size() != 9) begin
            errors++;
            $display("FAIL drop_count got=%0d exp=9", wlog.size());
        end else begin
            for (int k = 0; k < 9; k++) begin
                checks++;
                if (wlog[k] !== e[k]) begin
                    errors++;
                    $display("FAIL drop_w%0d got=%h exp=%h", k, wlog[k], e[k]);
                end
            end
            checks++;
            if (wcyc[1] - wcyc[0] != 2 || wcyc[8] - wcyc[3] != 5) begin
                errors++;
                $display("FAIL drop_timing got=%0d,%0d exp=2,5",
                         wcyc[1] - wcyc[0], wcyc[8] - wcyc[3]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int n0;
        do_reset(0);
        rem[2] = 8; nxt[2] = 8'h50;
        for (int c = 0; c < 6 && ecnt < 2; c++) begin
            src_cycle(0, 1'b0, 1'b0);
        end
        checks++;
        if (ecnt != 2) begin
            errors++;
            $display("FAIL rmid_pre got=%0d exp=2 beats", ecnt);
        end
        src_cycle(0, 1'b0, 1'b1);
        checks++;
        if (obs[12] !== 1'b0 || obs !== exp_obs) begin
            errors++;
            $display("FAIL rmid_rst obs=%h exp=%h wr=0", obs, exp_obs);
        end
        n0 = wlog.size();
        rem[1] = 1; nxt[1] = 8'h60;
        for (int c = 0; c < 4; c++) begin
            src_cycle(0, 1'b0, 1'b0);
            if (c == 0) begin
                checks++;
                if (obs[15] !== 1'b0) begin
                    errors++;
                    $display("FAIL rmid_gv got=%b exp=0", obs[15]);
                end
            end
            checks++;
            if (obs !== exp_obs) begin
                errors++;
                $display("FAIL rmid c%0d obs=%h exp=%h", c, obs, exp_obs);
            end
        end
        checks++;
        if (wlog.size() <= n0 || wlog[n0] !== 10'h160) begin
            errors++;
            $display("FAIL rmid_first got=%h exp=160",
                     (wlog.size() > n0) ? wlog[n0] : 10'h3FF);
        end
    endtask

    task automatic test_wrap3();
        logic [9:0] e[8];
        e = '{10'h080, 10'h081, 10'h2C0, 10'h2C1,
              10'h082, 10'h083, 10'h2C2, 10'h2C3};
        do_reset(1);
        rem[0] = 4; nxt[0] = 8'h80;
        rem[2] = 4; nxt[2] = 8'hC0;
        for (int c = 0; c < 11; c++) begin
            src_cycle(1, 1'b0, 1'b0);
            checks++;
            if (obs !== exp_obs) begin
                errors++;
                $display("FAIL wrap3 c%0d obs=%h exp=%h", c, obs, exp_obs);
            end
        end
        checks++;
        if (wlog.size() != 8) begin
            errors++;
            $display("FAIL wrap3_count got=%0d exp=8", wlog.size());
        end else begin
            for (int k = 0; k < 8; k++) begin
                checks++;
                if (wlog[k] !== e[k]) begin
                    errors++;
                    $display("FAIL wrap3_w%0d got=%h exp=%h", k, wlog[k], e[k]);
                end
            end
        end
    endtask

    task automatic test_random(input int w, input int ncyc);
        logic [3:0] v;
        do_reset(w);
        for (int c = 0; c < ncyc; c++) begin
            v = 4'($urandom_range(0, 15));
            if (w != 0) v[3] = 1'b0;
            step(w, v, $urandom(), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 63) == 0));
            checks++;
            if (obs !== exp_obs) begin
                errors++;
                $display("FAIL rand%0d c%0d obs=%h exp=%h",
                         w, c, obs, exp_obs);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; req_valid = '0; req_data = '0; fifo_full = 1'b0;
        rst3_n = 1'b0; req_valid3 = '0; req_data3 = '0; full3 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rem[i] = 0;
            nxt[i] = '0;
        end
        @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_all_valid();
        test_full_stall();
        test_drop();
        test_reset_mid();
        test_wrap3();
        test_random(0, 400);
        test_random(1, 200);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
